// File: rtl/ifetch_mem_responder.sv
// Instruction-fetch memory responder: reads four bytes from a byte-wide synchronous RAM and
// returns a little-endian word. Optional RVC early completion under IFR_COMPRESSED_SHORTCUT_EN.
module ifetch_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd_en,
    output logic [31:0]       data,
    output logic              data_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DRAIN} state_e;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } cap_t;

    state_e                    state_q;
    logic [ADDR_W-1:0]         mem_a_q;
    logic                      mem_rd_en_q;
    logic [1:0]                issue_idx_q;
    logic [23:0]               asm_q;
    logic [31:0]               data_q;
    logic                      data_ready_q;
    logic                      busy_q;
    cap_t [MEM_LAT-1:0]        pipe_q;
    cap_t [MEM_LAT-1:0]        pipe_d;
    cap_t                      cap;
`ifdef IFR_COMPRESSED_SHORTCUT_EN
    logic                      short_q;
    logic                      pipe_live_d;
`endif

    // Each read presented this cycle enters the pipe; its byte arrives MEM_LAT cycles later.
    always_comb begin
        pipe_d[0].vld = mem_rd_en_q;
        pipe_d[0].idx = issue_idx_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign cap = pipe_q[MEM_LAT-1];

`ifdef IFR_COMPRESSED_SHORTCUT_EN
    always_comb begin
        pipe_live_d = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            pipe_live_d = pipe_live_d | pipe_d[i].vld;
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: data_ready defaults low every cycle, so any branch that raises it yields a one-cycle pulse.
        data_ready_q <= 1'b0;
        if (rst) begin
            state_q     <= IDLE;
            mem_a_q     <= '0;
            mem_rd_en_q <= 1'b0;
            issue_idx_q <= 2'd0;
            asm_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            pipe_q      <= '0;
`ifdef IFR_COMPRESSED_SHORTCUT_EN
            short_q     <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= IDLE;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            pipe_q      <= '0;
        end else begin
            pipe_q <= pipe_d;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_a_q     <= req_addr;
                        mem_rd_en_q <= 1'b1;
                        issue_idx_q <= 2'd0;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
`ifdef IFR_COMPRESSED_SHORTCUT_EN
                        short_q     <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    if (issue_idx_q == 2'd3) begin
                        mem_rd_en_q <= 1'b0;
                        state_q     <= COLLECT;
                    end else begin
                        mem_a_q     <= mem_a_q + ADDR_W'(1);
                        issue_idx_q <= issue_idx_q + 2'd1;
                    end
                end
                COLLECT: begin
                end
                DRAIN: begin
`ifdef IFR_COMPRESSED_SHORTCUT_EN
                    if (!pipe_live_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase

            // Returning bytes override the issue decisions above when they end the fetch early.
            if (cap.vld && state_q != DRAIN && state_q != IDLE) begin
                unique case (cap.idx)
                    2'd0: begin
                        asm_q[7:0] <= mem_din;
`ifdef IFR_COMPRESSED_SHORTCUT_EN
                        if (mem_din[1:0] != 2'b11) begin
                            short_q <= 1'b1;
                            if (state_q == ISSUE) begin
                                mem_rd_en_q <= 1'b0;
                                mem_a_q     <= mem_a_q;
                                issue_idx_q <= issue_idx_q;
                                state_q     <= COLLECT;
                            end
                        end
`endif
                    end
                    2'd1: begin
                        asm_q[15:8] <= mem_din;
`ifdef IFR_COMPRESSED_SHORTCUT_EN
                        if (short_q) begin
                            data_q       <= {16'h0000, mem_din, asm_q[7:0]};
                            data_ready_q <= 1'b1;
                            if (pipe_live_d) begin
                                state_q <= DRAIN;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
`endif
                    end
                    2'd2: asm_q[23:16] <= mem_din;
                    2'd3: begin
                        data_q       <= {mem_din, asm_q};
                        data_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign data       = data_q;
    assign data_ready = data_ready_q;
    assign busy       = busy_q;

endmodule
